// File: rtl/cls_pwm_duty_cycle_meter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : cls_pwm_duty_cycle_meter_pkg
// Desc   : Percent-scaling constants and width helper shared by the meter.
// Rev    : 1.0 - initial release
// ============================================================================
package cls_pwm_duty_cycle_meter_pkg;

  localparam int PCT_SCALE  = 100;
  localparam int QUOT_WIDTH = 7;
  localparam int DIV_ITERS  = 7;

  // Position of the most significant set bit; 0 for inputs of 0 or 1.
  function automatic int bit_index(input int value);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cls_pwm_duty_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : cls_pwm_duty_divider
// Desc   : Restoring divider producing a 7-bit quotient, one bit per cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module cls_pwm_duty_divider
  import cls_pwm_duty_cycle_meter_pkg::*;
#(
  parameter  int DIVISOR_WIDTH  = 8,
  localparam int DIVIDEND_WIDTH = DIVISOR_WIDTH + QUOT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      busy,
  output logic                      done,
  output logic [QUOT_WIDTH-1:0]     quotient
);

  localparam int ITER_W = $clog2(DIV_ITERS + 1);

  logic [DIVIDEND_WIDTH-1:0] r_rem;
  logic [DIVIDEND_WIDTH-1:0] r_den;
  logic [QUOT_WIDTH-1:0]     r_q_work;
  logic [ITER_W-1:0]         r_iter;
  logic                      w_ge;
  logic [DIVIDEND_WIDTH-1:0] w_diff;

  // The divisor starts aligned to the top quotient bit and walks down.
  assign w_ge   = (r_rem >= r_den);
  assign w_diff = r_rem - r_den;
  assign busy   = (r_iter != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem    <= '0;
      r_den    <= '0;
      r_q_work <= '0;
      r_iter   <= '0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        r_rem    <= dividend;
        r_den    <= DIVIDEND_WIDTH'(divisor) << (DIV_ITERS - 1);
        r_q_work <= '0;
        r_iter   <= ITER_W'(DIV_ITERS);
      end else if (busy) begin
        if (w_ge) r_rem <= w_diff;
        r_den    <= r_den >> 1;
        r_q_work <= {r_q_work[QUOT_WIDTH-2:0], w_ge};
        r_iter   <= r_iter - ITER_W'(1);
        if (r_iter == ITER_W'(1)) begin
          done     <= 1'b1;
          quotient <= {r_q_work[QUOT_WIDTH-2:0], w_ge};
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cls_pwm_duty_cycle_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : cls_pwm_duty_cycle_meter
// Desc   : Measures high time, period and integer duty percent of a PWM input.
// Rev    : 1.0 - initial release
// ============================================================================
module cls_pwm_duty_cycle_meter
  import cls_pwm_duty_cycle_meter_pkg::*;
#(
  parameter  int CLK_RATE_HZ      = 50000000,
  parameter  int MIN_DUTY_RATE_HZ = 100,
  localparam int TIMEOUT_TICKS    = CLK_RATE_HZ / MIN_DUTY_RATE_HZ,
  localparam int CNT_WIDTH        = bit_index(TIMEOUT_TICKS) + 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PWM_IN,
  output logic [CNT_WIDTH-1:0]  HIGH_COUNT,
  output logic [CNT_WIDTH-1:0]  PERIOD_COUNT,
  output logic [QUOT_WIDTH-1:0] DUTY_PERCENT,
  output logic                  MEAS_VALID,
  output logic                  SIGNAL_LOST
);

  localparam int DIV_W = CNT_WIDTH + QUOT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] c_timeout = CNT_WIDTH'(TIMEOUT_TICKS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_sync1, r_sync2, r_sync3;
  logic [CNT_WIDTH-1:0]  r_cnt, r_hcnt, r_high_cap, r_period_cap;
  logic                  r_fall_seen;
  logic                  w_rise, w_fall, w_start;
  logic [CNT_WIDTH-1:0]  w_high_now;
  logic [DIV_W-1:0]      w_dividend;
  logic                  w_div_busy, w_div_done;
  logic [QUOT_WIDTH-1:0] w_quot;

  assign w_rise     = r_sync2 & ~r_sync3;
  assign w_fall     = ~r_sync2 & r_sync3;
  // A period with no falling edge was high throughout.
  assign w_high_now = r_fall_seen ? r_hcnt : r_cnt;
  assign w_start    = (r_state == ST_RUN) && w_rise && !w_div_busy;
  assign w_dividend = DIV_W'(w_high_now) * DIV_W'(PCT_SCALE);

  cls_pwm_duty_divider #(
    .DIVISOR_WIDTH(CNT_WIDTH)
  ) u_divider (
    .clk      (CLK),
    .rst      (RESET),
    .start    (w_start),
    .dividend (w_dividend),
    .divisor  (r_cnt),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_quot)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync3      <= 1'b0;
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_high_cap   <= '0;
      r_period_cap <= '0;
      r_fall_seen  <= 1'b0;
      HIGH_COUNT   <= '0;
      PERIOD_COUNT <= '0;
      DUTY_PERCENT <= '0;
      MEAS_VALID   <= 1'b0;
      SIGNAL_LOST  <= 1'b0;
    end else begin
      r_sync1    <= PWM_IN;
      r_sync2    <= r_sync1;
      r_sync3    <= r_sync2;
      MEAS_VALID <= 1'b0;

      if (w_fall) begin
        r_hcnt      <= r_cnt;
        r_fall_seen <= 1'b1;
      end

      if (w_div_done) begin
        HIGH_COUNT   <= r_high_cap;
        PERIOD_COUNT <= r_period_cap;
        DUTY_PERCENT <= w_quot;
        MEAS_VALID   <= 1'b1;
        SIGNAL_LOST  <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state     <= ST_RUN;
            r_cnt       <= CNT_WIDTH'(1);
            r_fall_seen <= 1'b0;
          end
        end
        ST_RUN: begin
          // A rise landing on the timeout cycle still counts as a period.
          if (w_rise) begin
            r_cnt       <= CNT_WIDTH'(1);
            r_fall_seen <= 1'b0;
            if (w_start) begin
              r_period_cap <= r_cnt;
              r_high_cap   <= w_high_now;
            end
          end else if (r_cnt == c_timeout) begin
            r_state      <= ST_IDLE;
            SIGNAL_LOST  <= 1'b1;
            DUTY_PERCENT <= r_sync2 ? QUOT_WIDTH'(PCT_SCALE) : '0;
            HIGH_COUNT   <= '0;
            PERIOD_COUNT <= '0;
            MEAS_VALID   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cls_pwm_duty_cycle_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_cls_pwm_duty_cycle_meter
// Desc   : Scoreboard bench for the PWM duty-cycle meter with a pin-level model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_cls_pwm_duty_cycle_meter;

  localparam int CW = 7;

  typedef struct {
    int cyc;
    int high;
    int period;
    int duty;
    bit lost;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] high_count, period_count;
  logic [6:0]    duty_percent;
  logic          meas_valid, signal_lost;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t last;

  // Reference model state, all in pin-time (negedge index when the pin is set).
  bit m_armed, m_have_acc, m_fseen, m_prev;
  int m_rise, m_fall, m_acc;

  cls_pwm_duty_cycle_meter #(
    .CLK_RATE_HZ      (1000),
    .MIN_DUTY_RATE_HZ (10)
  ) dut (
    .CLK          (clk),
    .RESET        (rst),
    .PWM_IN       (pwm_in),
    .HIGH_COUNT   (high_count),
    .PERIOD_COUNT (period_count),
    .DUTY_PERCENT (duty_percent),
    .MEAS_VALID   (meas_valid),
    .SIGNAL_LOST  (signal_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_armed = 0; m_have_acc = 0; m_fseen = 0; m_prev = 0;
    m_rise = 0; m_fall = 0; m_acc = 0;
    last = '{cyc: 0, high: 0, period: 0, duty: 0, lost: 1'b0};
  endtask

  // Rise-to-rise periods measured in pin time; the pin-to-strobe latency is
  // three synchronizer/edge cycles plus eight divider cycles.
  task automatic model_step(input bit lvl);
    int c, p, h;
    c = cyc;
    if (m_armed && c == m_rise + 101) begin
      q.push_back('{cyc: m_rise + 103, high: 0, period: 0,
                    duty: (m_prev ? 100 : 0), lost: 1'b1});
      m_armed = 0;
    end
    if (lvl && !m_prev) begin
      if (m_armed) begin
        p = c - m_rise;
        h = m_fseen ? (m_fall - m_rise) : p;
        if (!m_have_acc || (c - m_acc) >= 8) begin
          q.push_back('{cyc: c + 11, high: h, period: p, duty: (h * 100) / p, lost: 1'b0});
          m_acc = c;
          m_have_acc = 1;
        end
      end
      m_armed = 1;
      m_rise  = c;
      m_fseen = 0;
    end
    if (!lvl && m_prev && m_armed) begin
      m_fseen = 1;
      m_fall  = c;
    end
    m_prev = lvl;
  endtask

  task automatic drive(input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_step(lvl);
      pwm_in = lvl;
    end
  endtask

  task automatic pwm(input int high, input int period, input int reps);
    for (int i = 0; i < reps; i++) begin
      drive(1'b1, high);
      drive(1'b0, period - high);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_high_count"},   int'(high_count),   0);
    check({tag, "_period_count"}, int'(period_count), 0);
    check({tag, "_duty_percent"}, int'(duty_percent), 0);
    check({tag, "_meas_valid"},   int'(meas_valid),   0);
    check({tag, "_signal_lost"},  int'(signal_lost),  0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #1;
    rst    = 1'b1;
    pwm_in = 1'b0;
    q.delete();
    model_clear();
    #1;
    check_zero("async_reset");
    repeat (hold) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: pops one expectation per strobe, otherwise outputs must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          check("missed_strobe_cycle", cyc, e.cyc);
          last = e;
        end
        if (meas_valid) begin
          check("strobe_expected", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("strobe_cycle",  cyc,                e.cyc);
            check("high_count",    int'(high_count),   e.high);
            check("period_count",  int'(period_count), e.period);
            check("duty_percent",  int'(duty_percent), e.duty);
            check("signal_lost",   int'(signal_lost),  int'(e.lost));
            last = e;
          end
        end else begin
          check("hold_high_count",   int'(high_count),   last.high);
          check("hold_period_count", int'(period_count), last.period);
          check("hold_duty_percent", int'(duty_percent), last.duty);
          check("hold_signal_lost",  int'(signal_lost),  int'(last.lost));
        end
      end
    end
  end

  initial begin
    int p, h;
    model_clear();
    repeat (3) @(negedge clk);
    check_zero("reset");
    #1 rst = 1'b0;

    drive(1'b0, 5);
    pwm(10, 40, 4);
    pwm(10, 30, 3);
    pwm(19, 20, 3);
    drive(1'b1, 150);
    drive(1'b0, 10);
    drive(1'b1, 10);
    drive(1'b0, 150);
    pwm(20, 40, 4);
    pwm(3, 6, 10);
    pwm(30, 100, 3);

    for (int i = 0; i < 24; i++) begin
      p = (i % 8 == 7) ? int'($urandom_range(95, 110)) : int'($urandom_range(3, 60));
      h = int'($urandom_range(1, p - 1));
      pwm(h, p, 1);
    end
    drive(1'b0, 150);

    pwm(10, 40, 2);
    drive(1'b1, 7);
    do_reset(4);
    drive(1'b0, 5);
    pwm(10, 40, 3);
    drive(1'b0, 150);
    drive(1'b0, 20);

    check("pending_strobes", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
